// File: rtl/sram_ctl_pkg.sv
// Shared SRAM-controller definitions: arbiter FSM state encoding, select
// width and the SP/WRR mode encoding used by the write-path arbiters.
package sram_ctl_pkg;

  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam logic MODE_SP  = 1'b0;
  localparam logic MODE_WRR = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one finder: returns the first set bit of req at or after
// ptr, scanning upward and wrapping from NUM_PORTS-1 to 0.
//   req   : request vector
//   ptr   : scan start index
//   found : at least one request set
//   idx   : index of the winning request (0 when none)
module rr_pick #(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest offset down so the nearest hit to ptr is kept last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_port_scheduler.sv
// Packet-granular scheduler sharing the SRAM write path among NUM_PORTS
// ingress ports, in strict-priority or weighted round-robin mode. A grant
// is held from arbitration until the granted port's end-of-packet.
//   clk, rst_n  : clock, synchronous active-low reset
//   sp0_wrr1    : 0 = strict priority, 1 = weighted round-robin
//   ready       : per-port packet queued
//   eop         : per-port last beat this cycle
//   priority_in : per-port priority, PRI_W bits each
//   select      : granted port index (zero-extended)
//   transfering : grant active
//   grant_start : one-cycle pulse on first cycle of each grant
module wrr_port_scheduler
  import sram_ctl_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned PRI_W     = 3,
  parameter int unsigned CRD_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sp0_wrr1,
  input  logic [NUM_PORTS-1:0]       ready,
  input  logic [NUM_PORTS-1:0]       eop,
  input  logic [NUM_PORTS*PRI_W-1:0] priority_in,
  output logic [SEL_W-1:0]           select,
  output logic                       transfering,
  output logic                       grant_start
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic [CRD_W-1:0] credit [NUM_PORTS];
  logic             grant_wrr;

  logic [PRI_W-1:0]     pri [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible_c;
  logic [NUM_PORTS-1:0] pick_req_c;
  logic                 reload_c;
  logic                 rr_found_c;
  logic [IDX_W-1:0]     rr_idx_c;
  logic [IDX_W-1:0]     sp_idx_c;
  logic [PRI_W-1:0]     sp_best_c;
  logic                 sp_found_c;
  logic                 arb_go_c;
  logic [IDX_W-1:0]     cur_idx_c;
  logic [CRD_W-1:0]     cred_dec_c;

  // Unpack per-port priorities.
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      pri[i] = priority_in[i*PRI_W +: PRI_W];
    end
  end

  // WRR eligibility; an exhausted round falls back to plain ready.
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      eligible_c[i] = ready[i] && (credit[i] != '0);
    end
    reload_c   = (eligible_c == '0);
    pick_req_c = reload_c ? ready : eligible_c;
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req   (pick_req_c),
    .ptr   (ptr),
    .found (rr_found_c),
    .idx   (rr_idx_c)
  );

  // SP max-search; strict '>' keeps the lowest index on ties.
  always_comb begin
    sp_found_c = 1'b0;
    sp_best_c  = '0;
    sp_idx_c   = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (ready[i] && (!sp_found_c || (pri[i] > sp_best_c))) begin
        sp_found_c = 1'b1;
        sp_best_c  = pri[i];
        sp_idx_c   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    arb_go_c   = (sp0_wrr1 == MODE_WRR) ? rr_found_c : sp_found_c;
    cur_idx_c  = select[IDX_W-1:0];
    cred_dec_c = credit[cur_idx_c] - CRD_W'(1);
  end

  // Arbitration FSM with registered outputs and WRR credit/pointer state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      select      <= '0;
      transfering <= 1'b0;
      grant_start <= 1'b0;
      grant_wrr   <= 1'b0;
      ptr         <= '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) credit[i] <= '0;
    end else begin
      grant_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|ready) state <= ST_ARB;
        end
        ST_ARB: begin
          if (!arb_go_c) begin
            state <= ST_IDLE;
          end else begin
            state       <= ST_XFER;
            transfering <= 1'b1;
            grant_start <= 1'b1;
            grant_wrr   <= (sp0_wrr1 == MODE_WRR);
            if (sp0_wrr1 == MODE_WRR) begin
              select <= SEL_W'(rr_idx_c);
              if (reload_c) begin
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                  credit[i] <= CRD_W'(pri[i]) + CRD_W'(1);
                end
              end
            end else begin
              select <= SEL_W'(sp_idx_c);
            end
          end
        end
        ST_XFER: begin
          if (eop[cur_idx_c]) begin
            state       <= ST_IDLE;
            transfering <= 1'b0;
            // A port with credit left keeps its turn.
            if (grant_wrr) begin
              credit[cur_idx_c] <= cred_dec_c;
              ptr <= (cred_dec_c == '0) ? cur_idx_c + IDX_W'(1) : cur_idx_c;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
